// File: rtl/eee_bbox_multi.sv
`timescale 1ns/1ps
// Multi-colour bounding-box tracker on an Avalon-ST video stream, with an
// optional overlay that draws the previous frame's boxes onto the output.
module eee_bbox_multi #(
  parameter int NUM_COLOURS = 4,
  parameter int IMG_W       = 640,
  parameter int IMG_H       = 480,
  parameter int COORD_W     = 11,
  parameter int MIN_PIX     = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [23:0]                    sink_data,
  input  logic                           sink_valid,
  output logic                           sink_ready,
  input  logic                           sink_sop,
  input  logic                           sink_eop,
  output logic [23:0]                    source_data,
  output logic                           source_valid,
  input  logic                           source_ready,
  output logic                           source_sop,
  output logic                           source_eop,
  input  logic [NUM_COLOURS*24-1:0]      thr_lo,
  input  logic [NUM_COLOURS*24-1:0]      thr_hi,
  input  logic                           overlay_en,
  output logic [NUM_COLOURS*COORD_W-1:0] bbox_xmin,
  output logic [NUM_COLOURS*COORD_W-1:0] bbox_xmax,
  output logic [NUM_COLOURS*COORD_W-1:0] bbox_ymin,
  output logic [NUM_COLOURS*COORD_W-1:0] bbox_ymax,
  output logic [NUM_COLOURS-1:0]         bbox_valid,
  output logic                           frame_done
);

  localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST  = COORD_W'(IMG_H - 1);
  localparam logic [19:0]        MIN_CNT = 20'(MIN_PIX);

  typedef enum logic [1:0] {IDLE, HDR, VIDEO, CTRL} state_t;
  typedef logic [COORD_W-1:0] coord_t;

  state_t state_q, state_n;
  logic   hdr_video_q;
  logic   accept, in_video, pix, frame_end, clear_acc;

  logic [NUM_COLOURS*24-1:0] lo_q, hi_q;
  coord_t x_q, y_q;
  coord_t xmin_q [NUM_COLOURS], xmax_q [NUM_COLOURS], ymin_q [NUM_COLOURS], ymax_q [NUM_COLOURS];
  coord_t xmin_n [NUM_COLOURS], xmax_n [NUM_COLOURS], ymin_n [NUM_COLOURS], ymax_n [NUM_COLOURS];
  logic [19:0] cnt_q [NUM_COLOURS], cnt_n [NUM_COLOURS];
  coord_t bx_xmin_q [NUM_COLOURS], bx_xmax_q [NUM_COLOURS], bx_ymin_q [NUM_COLOURS], bx_ymax_q [NUM_COLOURS];
  logic [NUM_COLOURS-1:0] match;
  logic on_box;

  assign sink_ready = source_ready | ~source_valid;
  assign accept     = sink_valid & sink_ready;
  // HDR is the cycle after a header; its registered type already says whether beats are pixels.
  assign in_video   = (state_q == VIDEO) || ((state_q == HDR) && hdr_video_q);
  assign pix        = accept & ~sink_sop & in_video;
  assign frame_end  = pix & sink_eop;
  assign clear_acc  = accept & sink_sop & (in_video | (sink_data[3:0] == 4'h0));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      hdr_video_q <= 1'b0;
    end else begin
      state_q <= state_n;
      if (accept && sink_sop) hdr_video_q <= (sink_data[3:0] == 4'h0);
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_n = state_q;
    if (accept && sink_sop) begin
      state_n = sink_eop ? IDLE : HDR;
    end else begin
      unique case (state_q)
        HDR:         state_n = (accept && sink_eop) ? IDLE : (hdr_video_q ? VIDEO : CTRL);
        VIDEO, CTRL: if (accept && sink_eop) state_n = IDLE;
        default:     ;
      endcase
    end
  end

  always_comb begin
    match = '0;
    for (int c = 0; c < NUM_COLOURS; c++) begin
      match[c] = 1'b1;
      for (int k = 0; k < 3; k++) begin
        if (sink_data[8*k +: 8] < lo_q[24*c + 8*k +: 8] ||
            sink_data[8*k +: 8] > hi_q[24*c + 8*k +: 8])
          match[c] = 1'b0;
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_COLOURS; c++) begin
      xmin_n[c] = xmin_q[c];
      xmax_n[c] = xmax_q[c];
      ymin_n[c] = ymin_q[c];
      ymax_n[c] = ymax_q[c];
      cnt_n[c]  = cnt_q[c];
      if (clear_acc) begin
        xmin_n[c] = '0;
        xmax_n[c] = '0;
        ymin_n[c] = '0;
        ymax_n[c] = '0;
        cnt_n[c]  = '0;
      end else if (pix && match[c]) begin
        if (cnt_q[c] == 20'd0) begin
          xmin_n[c] = x_q;
          xmax_n[c] = x_q;
          ymin_n[c] = y_q;
          ymax_n[c] = y_q;
        end else begin
          if (x_q < xmin_q[c]) xmin_n[c] = x_q;
          if (x_q > xmax_q[c]) xmax_n[c] = x_q;
          if (y_q < ymin_q[c]) ymin_n[c] = y_q;
          if (y_q > ymax_q[c]) ymax_n[c] = y_q;
        end
        if (cnt_q[c] != 20'hFFFFF) cnt_n[c] = cnt_q[c] + 20'd1;
      end
    end
  end

  // NOTE: these register arrays are small and must read zero after reset, so they are reset explicitly.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q  <= '0;
      y_q  <= '0;
      lo_q <= '0;
      hi_q <= '0;
      for (int c = 0; c < NUM_COLOURS; c++) begin
        xmin_q[c] <= '0;
        xmax_q[c] <= '0;
        ymin_q[c] <= '0;
        ymax_q[c] <= '0;
        cnt_q[c]  <= '0;
      end
    end else begin
      if (accept && sink_sop && sink_data[3:0] == 4'h0) begin
        lo_q <= thr_lo;
        hi_q <= thr_hi;
      end
      if (clear_acc) begin
        x_q <= '0;
        y_q <= '0;
      end else if (pix) begin
        if (x_q == X_LAST) begin
          x_q <= '0;
          if (y_q != Y_LAST) y_q <= y_q + 1'b1;
        end else begin
          x_q <= x_q + 1'b1;
        end
      end
      for (int c = 0; c < NUM_COLOURS; c++) begin
        xmin_q[c] <= xmin_n[c];
        xmax_q[c] <= xmax_n[c];
        ymin_q[c] <= ymin_n[c];
        ymax_q[c] <= ymax_n[c];
        cnt_q[c]  <= cnt_n[c];
      end
    end
  end

  // Latch from the next-state accumulators so the eop pixel itself is included.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_done <= 1'b0;
      bbox_valid <= '0;
      for (int c = 0; c < NUM_COLOURS; c++) begin
        bx_xmin_q[c] <= '0;
        bx_xmax_q[c] <= '0;
        bx_ymin_q[c] <= '0;
        bx_ymax_q[c] <= '0;
      end
    end else begin
      frame_done <= frame_end;
      if (frame_end) begin
        for (int c = 0; c < NUM_COLOURS; c++) begin
          bbox_valid[c] <= (cnt_n[c] >= MIN_CNT);
          bx_xmin_q[c]  <= (cnt_n[c] >= MIN_CNT) ? xmin_n[c] : '0;
          bx_xmax_q[c]  <= (cnt_n[c] >= MIN_CNT) ? xmax_n[c] : '0;
          bx_ymin_q[c]  <= (cnt_n[c] >= MIN_CNT) ? ymin_n[c] : '0;
          bx_ymax_q[c]  <= (cnt_n[c] >= MIN_CNT) ? ymax_n[c] : '0;
        end
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_COLOURS; c++) begin
      bbox_xmin[c*COORD_W +: COORD_W] = bx_xmin_q[c];
      bbox_xmax[c*COORD_W +: COORD_W] = bx_xmax_q[c];
      bbox_ymin[c*COORD_W +: COORD_W] = bx_ymin_q[c];
      bbox_ymax[c*COORD_W +: COORD_W] = bx_ymax_q[c];
    end
  end

  always_comb begin
    on_box = 1'b0;
    for (int c = 0; c < NUM_COLOURS; c++) begin
      if (overlay_en && bbox_valid[c] &&
          (((x_q == bx_xmin_q[c] || x_q == bx_xmax_q[c]) && y_q >= bx_ymin_q[c] && y_q <= bx_ymax_q[c]) ||
           ((y_q == bx_ymin_q[c] || y_q == bx_ymax_q[c]) && x_q >= bx_xmin_q[c] && x_q <= bx_xmax_q[c])))
        on_box = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      source_valid <= 1'b0;
      source_data  <= '0;
      source_sop   <= 1'b0;
      source_eop   <= 1'b0;
    end else if (accept) begin
      source_valid <= 1'b1;
      source_data  <= (pix && on_box) ? 24'hFFFFFF : sink_data;
      source_sop   <= sink_sop;
      source_eop   <= sink_eop;
    end else if (source_ready) begin
      source_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_eee_bbox_multi.sv
`timescale 1ns/1ps
// Directed bench for eee_bbox_multi on an 8x4 image with two colour classes:
// red (colour 0) and green (colour 1), minimum two pixels per box.
module tb_eee_bbox_multi;
  localparam int NC = 2, W = 8, H = 4, CW = 11, MP = 2;
  localparam logic [23:0] RED = 24'hFF0000, GREEN = 24'h00FF00;

  logic clk = 1'b0, reset = 1'b1;
  logic [23:0] sink_data = '0, source_data;
  logic sink_valid = 1'b0, sink_ready, sink_sop = 1'b0, sink_eop = 1'b0;
  logic source_valid, source_ready = 1'b1, source_sop, source_eop;
  logic [NC*24-1:0] thr_lo = {GREEN, RED}, thr_hi = {GREEN, RED};
  logic overlay_en = 1'b0;
  logic [NC*CW-1:0] bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax;
  logic [NC-1:0] bbox_valid;
  logic frame_done;

  always #5 clk = ~clk;

  eee_bbox_multi #(.NUM_COLOURS(NC), .IMG_W(W), .IMG_H(H), .COORD_W(CW), .MIN_PIX(MP)) dut (
    .clk(clk), .reset(reset),
    .sink_data(sink_data), .sink_valid(sink_valid), .sink_ready(sink_ready),
    .sink_sop(sink_sop), .sink_eop(sink_eop),
    .source_data(source_data), .source_valid(source_valid), .source_ready(source_ready),
    .source_sop(source_sop), .source_eop(source_eop),
    .thr_lo(thr_lo), .thr_hi(thr_hi), .overlay_en(overlay_en),
    .bbox_xmin(bbox_xmin), .bbox_xmax(bbox_xmax), .bbox_ymin(bbox_ymin), .bbox_ymax(bbox_ymax),
    .bbox_valid(bbox_valid), .frame_done(frame_done)
  );

  typedef struct packed {logic [23:0] d; logic sop; logic eop;} beat_t;
  beat_t out_q[$];
  beat_t exp_q[$];
  int errors = 0, checks = 0, fd_count = 0;
  logic [23:0] pix_mem [48];

  // Output-side monitor: a beat is transferred when valid and ready are both high.
  always @(negedge clk) begin
    if (!reset && source_valid && source_ready) out_q.push_back({source_data, source_sop, source_eop});
    if (frame_done) fd_count++;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 100us");
    $fatal(1);
  end

  // All stimulus changes at posedge+1; all sampling on negedge.
  task automatic send(input logic [23:0] d, input logic sop, input logic eop);
    int guard;
    guard = 0;
    sink_data = d; sink_valid = 1'b1; sink_sop = sop; sink_eop = eop;
    @(negedge clk);
    while (!sink_ready && guard < 200) begin guard++; @(negedge clk); end
    if (!sink_ready) begin
      errors++; checks++;
      $display("FAIL send_timeout: sink_ready=%b required 1", sink_ready);
    end
    @(posedge clk); #1;
    sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
  endtask

  task automatic clear_pix();
    for (int i = 0; i < 48; i++) pix_mem[i] = {8'h20, 8'(i), 8'h40};
  endtask

  function automatic logic [23:0] exp_pix(input int i, input bit ovl);
    int x, y;
    x = i % W;
    y = i / W;
    if (y > H - 1) y = H - 1;
    if (ovl && ((((x == 2) || (x == 5)) && y >= 1 && y <= 2) || (((y == 1) || (y == 2)) && x >= 2 && x <= 5)))
      return 24'hFFFFFF;
    return pix_mem[i];
  endfunction

  task automatic build_video(input int n, input bit ovl);
    exp_q.push_back({24'h000000, 1'b1, 1'b0});
    for (int i = 0; i < n; i++) exp_q.push_back({exp_pix(i, ovl), 1'b0, (i == n - 1)});
  endtask

  task automatic send_video(input int n);
    send(24'h000000, 1'b1, 1'b0);
    for (int i = 0; i < n; i++) send(pix_mem[i], 1'b0, (i == n - 1));
  endtask

  task automatic check_stream(input string name);
    int n;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (out_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_beats: got %0d beats, required %0d", name, out_q.size(), exp_q.size());
    end
    n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (out_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s_beat%0d: got data=%h sop=%b eop=%b, required data=%h sop=%b eop=%b",
                 name, i, out_q[i].d, out_q[i].sop, out_q[i].eop, exp_q[i].d, exp_q[i].sop, exp_q[i].eop);
      end
    end
    out_q.delete();
    exp_q.delete();
  endtask

  // Called at posedge+1 right after the eop beat was accepted.
  task automatic expect_done(input string name);
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b1) begin errors++; $display("FAIL %s_done_pulse: got %b required 1", name, frame_done); end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL %s_done_width: got %b required 0", name, frame_done); end
    @(posedge clk); #1;
  endtask

  task automatic check_box(input string name, input int c, input int xmn, input int xmx,
                           input int ymn, input int ymx, input logic v);
    logic [4*CW-1:0] got, req;
    checks++;
    if (bbox_valid[c] !== v) begin
      errors++; $display("FAIL %s_valid%0d: got %b required %b", name, c, bbox_valid[c], v);
    end
    got = {bbox_xmin[c*CW +: CW], bbox_xmax[c*CW +: CW], bbox_ymin[c*CW +: CW], bbox_ymax[c*CW +: CW]};
    req = {CW'(xmn), CW'(xmx), CW'(ymn), CW'(ymx)};
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s_box%0d: got x=%0d..%0d y=%0d..%0d, required x=%0d..%0d y=%0d..%0d", name, c,
               got[4*CW-1 -: CW], got[3*CW-1 -: CW], got[2*CW-1 -: CW], got[CW-1:0], xmn, xmx, ymn, ymx);
    end
  endtask

  task automatic check_all_zero(input string name);
    @(negedge clk);
    checks++;
    if (source_valid !== 1'b0) begin errors++; $display("FAIL %s_source_valid: got %b required 0", name, source_valid); end
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL %s_frame_done: got %b required 0", name, frame_done); end
    checks++;
    if (sink_ready !== 1'b1) begin errors++; $display("FAIL %s_sink_ready: got %b required 1", name, sink_ready); end
    @(posedge clk); #1;
    check_box(name, 0, 0, 0, 0, 0, 1'b0);
    check_box(name, 1, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_reset();
    check_all_zero("reset");
  endtask

  task automatic test_basic();
    clear_pix();
    pix_mem[10] = RED;
    pix_mem[21] = RED;
    build_video(32, 1'b0);
    send_video(32);
    expect_done("basic");
    check_box("basic", 0, 2, 5, 1, 2, 1'b1);
    check_box("basic", 1, 0, 0, 0, 0, 1'b0);
    check_stream("basic");
  endtask

  task automatic test_single();
    clear_pix();
    pix_mem[10] = RED;
    build_video(32, 1'b0);
    send_video(32);
    expect_done("single");
    check_box("single", 0, 0, 0, 0, 0, 1'b0);
    check_stream("single");
  endtask

  task automatic test_back_pressure();
    logic [23:0] held;
    clear_pix();
    pix_mem[10] = RED;
    pix_mem[21] = RED;
    build_video(32, 1'b0);
    fork
      send_video(32);
      begin
        repeat (12) @(posedge clk);
        #1 source_ready = 1'b0;
        @(negedge clk);
        held = source_data;
        checks++;
        if (source_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_start: got %b required 1", source_valid); end
        repeat (4) begin
          @(negedge clk);
          checks++;
          if (source_data !== held || source_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold: got data=%h valid=%b, required data=%h valid=1", source_data, source_valid, held);
          end
        end
        @(posedge clk); #1 source_ready = 1'b1;
      end
    join
    expect_done("bp");
    check_box("bp", 0, 2, 5, 1, 2, 1'b1);
    check_stream("bp");
  endtask

  task automatic test_control();
    int fd0;
    fd0 = fd_count;
    exp_q.push_back({24'h00000F, 1'b1, 1'b0});
    exp_q.push_back({RED, 1'b0, 1'b0});
    exp_q.push_back({24'h123456, 1'b0, 1'b1});
    send(24'h00000F, 1'b1, 1'b0);
    send(RED, 1'b0, 1'b0);
    send(24'h123456, 1'b0, 1'b1);
    check_stream("ctrl");
    checks++;
    if (fd_count != fd0) begin errors++; $display("FAIL ctrl_no_done: got %0d pulses, required %0d", fd_count, fd0); end
    check_box("ctrl", 0, 2, 5, 1, 2, 1'b1);
  endtask

  task automatic test_overlay();
    overlay_en = 1'b1;
    clear_pix();
    pix_mem[10] = RED;
    pix_mem[21] = RED;
    build_video(32, 1'b1);
    send_video(32);
    expect_done("ovl");
    check_box("ovl", 0, 2, 5, 1, 2, 1'b1);
    check_stream("ovl");
    overlay_en = 1'b0;
  endtask

  task automatic test_short_long();
    clear_pix();
    pix_mem[10] = RED;
    pix_mem[11] = RED;
    build_video(12, 1'b0);
    send_video(12);
    expect_done("short");
    check_box("short", 0, 2, 3, 1, 1, 1'b1);
    check_box("short", 1, 0, 0, 0, 0, 1'b0);
    check_stream("short");
    clear_pix();
    pix_mem[0]  = GREEN;
    pix_mem[31] = GREEN;
    pix_mem[33] = GREEN;
    build_video(36, 1'b0);
    send_video(36);
    expect_done("long");
    check_box("long", 1, 0, 7, 0, 3, 1'b1);
    check_box("long", 0, 0, 0, 0, 0, 1'b0);
    check_stream("long");
  endtask

  task automatic test_sop_reset();
    int fd0;
    fd0 = fd_count;
    clear_pix();
    pix_mem[0] = RED;
    send(24'h000000, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) send(pix_mem[i], 1'b0, 1'b0);
    clear_pix();
    pix_mem[10] = RED;
    pix_mem[21] = RED;
    send_video(32);
    expect_done("restart");
    checks++;
    if (fd_count != fd0 + 1) begin errors++; $display("FAIL restart_pulses: got %0d, required %0d", fd_count, fd0 + 1); end
    check_box("restart", 0, 2, 5, 1, 2, 1'b1);
    send(24'h000000, 1'b1, 1'b0);
    for (int i = 8; i < 11; i++) send(pix_mem[i], 1'b0, 1'b0);
    fd0 = fd_count;
    sink_data = RED; sink_valid = 1'b1; sink_eop = 1'b1; reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0; sink_valid = 1'b0; sink_eop = 1'b0;
    check_all_zero("midreset");
    checks++;
    if (fd_count != fd0) begin errors++; $display("FAIL midreset_no_done: got %0d, required %0d", fd_count, fd0); end
    out_q.delete();
    build_video(32, 1'b0);
    send_video(32);
    expect_done("after_reset");
    check_box("after_reset", 0, 2, 5, 1, 2, 1'b1);
    check_stream("after_reset");
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    test_reset();
    test_basic();
    test_single();
    test_back_pressure();
    test_control();
    test_overlay();
    test_short_long();
    test_sop_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eee_bbox_multi.md
EEE_BBOX_MULTI -- requirements
Module: eee_bbox_multi

Parameters
REQ-001 SHALL have parameter NUM_COLOURS, default 4, meaning the number of independent colour classes tracked (legal range 1..8).
REQ-002 SHALL have parameter IMG_W, default 640, meaning the active pixels per line.
REQ-003 SHALL have parameter IMG_H, default 480, meaning the active lines per frame.
REQ-004 SHALL have parameter COORD_W, default 11, meaning the coordinate width in bits.
REQ-005 SHALL have parameter MIN_PIX, default 16, meaning the minimum matching-pixel count for a valid bbox.

Interface
REQ-006 SHALL have port clk, input, 1 bit, the single clock for all logic.
REQ-007 SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-008 SHALL have sink_data (in, 24), sink_valid (in, 1), sink_ready (out, 1), sink_sop (in, 1), sink_eop (in, 1): Avalon-ST video in, R=[23:16], G=[15:8], B=[7:0].
REQ-009 SHALL have source_data (out, 24), source_valid (out, 1), source_ready (in, 1), source_sop (out, 1), source_eop (out, 1): Avalon-ST video out.
REQ-010 SHALL have thr_lo and thr_hi, each input, NUM_COLOURS*24 bits: per-colour inclusive RGB bounds, colour c at [24c+23:24c].
REQ-011 SHALL have overlay_en, input, 1 bit: draw the previous-frame boxes onto the output video.
REQ-012 SHALL have bbox_xmin, bbox_xmax, bbox_ymin and bbox_ymax, each output, NUM_COLOURS*COORD_W bits: latched box per colour.
REQ-013 SHALL have bbox_valid, output, NUM_COLOURS bits: per-colour flag, box meaningful.
REQ-014 SHALL have frame_done, output, 1 bit: one-cycle pulse when the bbox outputs update.

Function
REQ-015 Handshake: sink_ready SHALL equal source_ready OR NOT source_valid; a beat is accepted when sink_valid AND sink_ready.
REQ-016 Output register: each accepted beat SHALL appear on source_* exactly 1 cycle later; source_* SHALL be held stable while source_valid AND NOT source_ready.
REQ-017 Packet typing: the first beat after sop SHALL be a header; low nibble 0 marks a video packet, any other value a control packet.
REQ-018 Header and control-packet beats SHALL pass through unmodified, and control packets SHALL NOT touch the counters.
REQ-019 Colour match: within a video packet each pixel beat SHALL be tested per colour c.
REQ-020 A pixel matches colour c iff lo <= chan <= hi for all three channels.
REQ-021 thr_lo/thr_hi SHALL be sampled at the video header beat and held for the whole frame.
REQ-022 Coordinate counters x,y SHALL start at 0 on the first pixel; x SHALL wrap at IMG_W-1 to 0 with y+1; y SHALL saturate at IMG_H-1.
REQ-023 Accumulators: per colour, min/max x,y of matching pixels plus a 20-bit saturating match count.
REQ-024 Accumulators SHALL be cleared at the video header.
REQ-025 Frame end (eop beat of a video packet accepted): next cycle, frame_done=1 for 1 cycle and bbox_* updated.
REQ-026 bbox_valid[c] SHALL be 1 iff count_c >= MIN_PIX; otherwise that colour's coordinates SHALL read 0.
REQ-027 Short frame (eop before IMG_W*IMG_H pixels) SHALL still latch as in REQ-025; a long frame latches at eop with y saturated.
REQ-028 A sop arriving inside a video packet without eop SHALL discard the partial accumulators, skip the frame_done pulse, and start a new packet.
REQ-029 Overlay: if overlay_en and bbox_valid[c], a pixel SHALL be replaced by 24'hFFFFFF when it lies on the latched box perimeter.
REQ-030 The perimeter is (x==xmin or x==xmax, ymin<=y<=ymax) or (y==ymin or y==ymax, xmin<=x<=xmax); overlay uses the latched (previous-frame) boxes.
REQ-031 State machine: IDLE -> HDR on sop; HDR -> VIDEO (type 0) or CTRL (other type); VIDEO/CTRL -> IDLE on eop; any state -> HDR on sop (REQ-028).
REQ-032 A single-beat packet (sop and eop together) SHALL return to IDLE.
REQ-033 A frame_done pulse SHALL NOT be lost under back-pressure; the latch occurs on eop acceptance, independent of source_ready.

Reset
REQ-034 With reset=1 at a clk edge: source_valid=0, frame_done=0, bbox_*=0, bbox_valid=0, state=IDLE, counters/accumulators cleared.
REQ-035 Reset asserted mid-frame SHALL drop the in-flight beat and the partial frame; sink_ready SHALL be 1 on the cycle after reset deasserts.

Verification (IMG_W=8, IMG_H=4, NUM_COLOURS=2, MIN_PIX=2)
REQ-036 Setup: colour0 thresholds lo=FF0000, hi=FF0000; frame with red at (2,1),(5,2).
Expect frame_done 1 cycle after eop; box0 = 2,5,1,2; bbox_valid=2'b01.
REQ-037 Single red pixel only -> bbox_valid[0]=0 and box0 = 0.
REQ-038 Hold source_ready=0 for 5 cycles mid-frame -> source_data stable, no beat lost or duplicated, same bbox as REQ-036.
REQ-039 Control packet (header 0xF) between frames -> passed bit-exact; bbox and counters unchanged; no frame_done.
REQ-040 Second frame with overlay_en=1 -> pixels on rectangle (2..5, 1..2) perimeter output FFFFFF; all others unchanged.
REQ-041 sop mid-frame, then reset mid-frame -> no frame_done; all outputs 0 after reset; the next full frame latches correctly.
